// File: rtl/mips32_prog_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips32_prog_loader: framed byte stream -> MIPS32 memory, then runs core.  |
// | Optional build macro LOADER_TIMEOUT_EN enables the inter-byte watchdog.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips32_prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  input  logic              cpu_halted,
  input  logic              clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [7:0]        c_sync    = 8'hA5;
  localparam logic [16:0]       c_max_len = 17'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(BASE_ADDR);

  state_t      r_state, w_next;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_asm;
  logic [7:0]  r_csum;

  logic        w_rx;
  logic        w_fire;
  logic        w_timeout;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_last_byte;

  assign w_rx        = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                       (r_state == S_DATA)   || (r_state == S_CSUM);
  assign in_ready    = (r_state == S_IDLE) || w_rx;
  assign busy        = w_rx || (r_state == S_RUN);
  assign w_fire      = in_valid && in_ready;
  assign w_len       = {r_len_hi, in_data};
  assign w_len_bad   = ({1'b0, w_len} > c_max_len);
  assign w_last_byte = (r_byte_idx == 2'd3) && (r_word_idx == r_len - 16'd1);

`ifdef LOADER_TIMEOUT_EN
  localparam int c_idle_w = $clog2(TIMEOUT_CYC + 1);
  logic [c_idle_w-1:0] r_idle;

  // Counts idle cycles since the last accepted byte while a frame is open.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if (!w_rx || w_fire) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end

  assign w_timeout = w_rx && !w_fire && (r_idle == c_idle_w'(TIMEOUT_CYC - 1));
`else
  // Never asserted: without the watchdog the loader waits indefinitely.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fire && in_data == c_sync) w_next = S_LEN_HI;
      S_LEN_HI: if (w_fire) w_next = S_LEN_LO;
      S_LEN_LO: if (w_fire) w_next = w_len_bad ? S_ERR : ((w_len == 16'd0) ? S_CSUM : S_DATA);
      S_DATA:   if (w_fire && w_last_byte) w_next = S_CSUM;
      S_CSUM:   if (w_fire) w_next = (in_data == r_csum) ? S_RUN : S_ERR;
      S_RUN:    if (cpu_halted) w_next = S_DONE;
      S_DONE:   if (clr) w_next = S_IDLE;
      S_ERR:    if (clr) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_ERR;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_len_hi   <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_csum     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= c_base;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      mem_we <= 1'b0;
      if (w_fire) begin
        case (r_state)
          S_IDLE: begin
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
          end
          S_LEN_HI: r_len_hi <= in_data;
          S_LEN_LO: r_len    <= w_len;
          S_DATA: begin
            r_csum     <= r_csum ^ in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            r_asm      <= {r_asm[15:0], in_data};
            if (r_byte_idx == 2'd3) begin
              mem_we     <= 1'b1;
              mem_addr   <= c_base + ADDR_W'(r_word_idx);
              mem_wdata  <= {r_asm, in_data};
              r_word_idx <= r_word_idx + 16'd1;
            end
          end
          S_CSUM: if (in_data == r_csum) cpu_hold <= 1'b0;
          default: ;
        endcase
      end
      if (r_state == S_RUN && cpu_halted) begin
        done     <= 1'b1;
        cpu_hold <= 1'b1;
      end
      // Timeout and byte-driven errors are exclusive: a timeout needs an idle cycle.
      if (w_next == S_ERR && r_state != S_ERR) begin
        err      <= 1'b1;
        err_code <= w_timeout ? 2'd3 : ((r_state == S_LEN_LO) ? 2'd1 : 2'd2);
      end
      if ((r_state == S_DONE || r_state == S_ERR) && clr) begin
        done     <= 1'b0;
        err      <= 1'b0;
        err_code <= 2'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips32_prog_loader.sv
`default_nettype none
// Bench for mips32_prog_loader: frames driven byte by byte, expected writes and
// outcomes derived from the frame contents.
module tb_mips32_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int BASE   = 0;
  localparam int TO_CYC = 16;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_halted;
  logic              clr;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  mips32_prog_loader #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .cpu_halted(cpu_halted), .clr(clr), .busy(busy),
    .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every cycle: each write strobe must match the next expected write exactly.
  always @(negedge clk1) begin
    if (rst_n) begin
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), w.addr);
          chk("wr_data", mem_wdata, w.data);
          chk("wr_cycle", cyc, w.cyc);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        wr_t w;
        w = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_write: no strobe, expected addr 0x%0h data 0x%0h", w.addr, w.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic put_byte(input logic [7:0] b, input int stall, input bit push,
                          input logic [31:0] addr, input logic [31:0] data, output int acc);
    int n;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b0;
      @(negedge clk1);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk1);
      n++;
    end
    if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
    acc = cyc + 1;
    @(posedge clk1);
    if (push) exp_q.push_back('{addr: addr, data: data, cyc: acc});
    @(negedge clk1);
    in_valid = 1'b0;
  endtask

  function automatic int pick_stall(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  function automatic logic [7:0] ref_csum(input logic [31:0] w[$]);
    logic [7:0] x = 8'h00;
    foreach (w[k]) x = x ^ w[k][31:24] ^ w[k][23:16] ^ w[k][15:8] ^ w[k][7:0];
    return x;
  endfunction

  int last_acc;

  task automatic send_frame(input logic [31:0] w[$], input logic [15:0] len,
                            input logic [7:0] flip, input int mode);
    int acc;
    logic [7:0] b;
    put_byte(8'hA5, pick_stall(mode), 1'b0, 0, 0, acc);
    chk("busy_after_sync", 32'(busy), 32'd1);
    put_byte(len[15:8], pick_stall(mode), 1'b0, 0, 0, acc);
    put_byte(len[7:0], pick_stall(mode), 1'b0, 0, 0, acc);
    if (int'(len) > DEPTH - BASE) return;
    for (int k = 0; k < int'(len); k++) begin
      for (int j = 0; j < 4; j++) begin
        b = w[k][31 - 8*j -: 8];
        put_byte(b, pick_stall(mode), (j == 3), 32'(BASE + k), w[k], acc);
      end
    end
    put_byte(ref_csum(w) ^ flip, pick_stall(mode), 1'b0, 0, 0, acc);
    last_acc = acc;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk1);
    clr = 1'b0;
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_code", 32'(err_code), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    chk("clr_hold", 32'(cpu_hold), 32'd1);
  endtask

  task automatic expect_run();
    int k;
    chk("run_hold", 32'(cpu_hold), 32'd0);
    chk("run_ready", 32'(in_ready), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_err", 32'(err), 32'd0);
    clr = 1'b1;
    @(negedge clk1);
    clr = 1'b0;
    chk("run_clr_ignored", 32'(cpu_hold), 32'd0);
    k = int'($urandom_range(2, 8));
    repeat (k) @(negedge clk1);
    cpu_halted = 1'b1;
    @(negedge clk1);
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_hold", 32'(cpu_hold), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_ready", 32'(in_ready), 32'd0);
    cpu_halted = 1'b0;
    @(negedge clk1);
    chk("done_holds", 32'(done), 32'd1);
    do_clr();
  endtask

  task automatic expect_err(input logic [1:0] code);
    chk("err_flag", 32'(err), 32'd1);
    chk("err_code", 32'(err_code), 32'(code));
    chk("err_hold", 32'(cpu_hold), 32'd1);
    chk("err_ready", 32'(in_ready), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);
    @(negedge clk1);
    chk("err_sticky", 32'(err), 32'd1);
    do_clr();
  endtask

  task automatic rand_words(input int n, output logic [31:0] w[$]);
    w = {};
    for (int i = 0; i < n; i++) w.push_back($urandom);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] prog[$];
  logic [31:0] ws[$];
  int acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; cpu_halted = 1'b0; clr = 1'b0;
    prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
             32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
             32'hfc000000};
    repeat (3) @(negedge clk1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", {29'd0, done, err_code}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk1);

    // Program image: model checksum pinned to a hand-computed value.
    chk("model_csum", 32'(ref_csum(prog)), 32'h5D);
    foreach (ws[i]) ws.delete(i);
    put_byte(8'h00, 0, 1'b0, 0, 0, acc);
    put_byte(8'hFF, 0, 1'b0, 0, 0, acc);
    put_byte(8'h5A, 0, 1'b0, 0, 0, acc);
    chk("garbage_idle", 32'(busy), 32'd0);
    send_frame(prog, 16'd11, 8'h00, 0);
    chk("good_last_addr", 32'(mem_addr), 32'd10);
    chk("good_last_data", mem_wdata, 32'hfc000000);
    expect_run();

    send_frame(prog, 16'd11, 8'h01, 0);
    expect_err(2'd2);

    send_frame(prog, 16'h0401, 8'h00, 0);
    expect_err(2'd1);

    rand_words(1024, ws);
    send_frame(ws, 16'h0400, 8'h00, 0);
    chk("full_last_addr", 32'(mem_addr), 32'd1023);
    expect_run();

    ws = {};
    send_frame(ws, 16'd0, 8'h00, 0);
    expect_run();

    rand_words(5, ws);
    send_frame(ws, 16'd5, 8'h00, 1);
    expect_run();

    // Reset in the middle of the second payload word.
    put_byte(8'hA5, 0, 1'b0, 0, 0, acc);
    put_byte(8'h00, 0, 1'b0, 0, 0, acc);
    put_byte(8'h03, 0, 1'b0, 0, 0, acc);
    for (int j = 0; j < 6; j++)
      put_byte(8'h10 + 8'(j), 0, (j == 3), 32'(BASE), 32'h10111213, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("amid_ready", 32'(in_ready), 32'd1);
    chk("amid_busy", 32'(busy), 32'd0);
    chk("amid_hold", 32'(cpu_hold), 32'd1);
    chk("amid_wdata", mem_wdata, 32'd0);
    chk("amid_addr", 32'(mem_addr), 32'(BASE));
    exp_q = {};
    @(negedge clk1);
    rst_n = 1'b1;
    @(negedge clk1);
    send_frame(prog, 16'd11, 8'h00, 2);
    expect_run();

`ifdef LOADER_TIMEOUT_EN
    put_byte(8'hA5, 0, 1'b0, 0, 0, acc);
    put_byte(8'h00, 0, 1'b0, 0, 0, acc);
    put_byte(8'h02, 0, 1'b0, 0, 0, acc);
    put_byte(8'h11, 0, 1'b0, 0, 0, acc);
    put_byte(8'h22, 0, 1'b0, 0, 0, acc);
    for (int n = 0; n < 40 && !err; n++) @(negedge clk1);
    chk("timeout_delay", cyc - acc, 32'(TO_CYC));
    expect_err(2'd3);
`else
    put_byte(8'hA5, 0, 1'b0, 0, 0, acc);
    put_byte(8'h00, 0, 1'b0, 0, 0, acc);
    put_byte(8'h01, 0, 1'b0, 0, 0, acc);
    put_byte(8'hDE, 0, 1'b0, 0, 0, acc);
    repeat (40) @(negedge clk1);
    chk("no_timeout", 32'(err), 32'd0);
    put_byte(8'hAD, 0, 1'b0, 0, 0, acc);
    put_byte(8'hBE, 0, 1'b0, 0, 0, acc);
    put_byte(8'hEF, 0, 1'b1, 32'(BASE), 32'hDEADBEEF, acc);
    put_byte(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, 0, 1'b0, 0, 0, acc);
    expect_run();
`endif

    for (int f = 0; f < 6; f++) begin
      int nw;
      logic [7:0] flip;
      int ng;
      nw = int'($urandom_range(1, 12));
      rand_words(nw, ws);
      flip = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      ng = int'($urandom_range(0, 3));
      for (int g = 0; g < ng; g++) begin
        logic [7:0] gb;
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h00;
        put_byte(gb, 0, 1'b0, 0, 0, acc);
      end
      send_frame(ws, 16'(nw), flip, int'($urandom_range(0, 2)));
      if (flip == 8'h00) expect_run();
      else expect_err(2'd2);
    end

    repeat (3) @(negedge clk1);
    chk("no_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
Upstream boot stage for the pipelined MIPS32 core. It receives a framed byte stream and assembles big-endian 32-bit words. Each word is written into the core's unified instruction/data memory through a single write port. After a frame passes its checksum, the block holds the core in halt state, releases it to run, and reports when the core asserts HALTED. This replaces hierarchical memory pokes with a synthesizable load path.

Parameters:
ADDR_W, 10, width of memory word address
DEPTH, 1024, number of writable memory words; frame length above this is rejected
BASE_ADDR, 0, word address written by the first payload word
TIMEOUT_CYC, 4096, inter-byte idle limit in clk1 cycles (used only with the optional feature)

Ports:
clk1  in  1  single system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
in_data  in  8  stream byte
in_valid  in  1  byte present
in_ready  out  1  loader accepts byte; transfer happens when in_valid and in_ready are both high
mem_we  out  1  one-cycle memory write strobe
mem_addr  out  ADDR_W  write word address
mem_wdata  out  32  write data
cpu_hold  out  1  high holds the core halted with PC forced to BASE_ADDR
cpu_halted  in  1  core HALTED flag
clr  in  1  synchronous return from DONE/ERR to IDLE
busy  out  1  frame in progress or core running
done  out  1  core reached HLT after a good load
err  out  1  sticky error
err_code  out  2  0 none, 1 length, 2 checksum, 3 timeout

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE; in_ready=1; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0.
  - cpu_hold=1; busy=0; done=0; err=0; err_code=0.
  - Word count, byte index and checksum all cleared.
- Frame format: sync 0xA5, LEN_HI, LEN_LO, 4*LEN payload bytes (MSB first per word), then CSUM. CSUM is the XOR of all payload bytes; with LEN=0 it is 0x00.
- States: IDLE, LEN_HI, LEN_LO, DATA, CSUM, RUN, DONE, ERR.
- IDLE:
  - Bytes other than 0xA5 are consumed and discarded.
  - 0xA5 -> LEN_HI and busy=1.
- LEN_HI, LEN_LO:
  - Latch the 16-bit length.
  - At LEN_LO, if LEN > DEPTH-BASE_ADDR -> ERR with code 1.
  - LEN=0 -> CSUM; otherwise -> DATA.
- DATA:
  - Shift each byte into the assembly register and XOR it into the checksum.
  - On the 4th byte of a word, in the next cycle: mem_we=1 for exactly one cycle, mem_addr=BASE_ADDR+word_idx, mem_wdata=assembled word.
  - Write latency is 1 cycle after the accepting edge.
  - After the last word -> CSUM.
- CSUM:
  - On match -> RUN: cpu_hold deasserts the cycle after acceptance; in_ready=0.
  - On mismatch -> ERR with code 2; cpu_hold stays 1.
- RUN:
  - in_ready=0.
  - When cpu_halted=1 -> DONE: done=1, busy=0, cpu_hold=1.
- DONE, ERR:
  - in_ready=0; outputs hold.
  - clr=1 -> IDLE, clearing done/err/err_code; cpu_hold stays 1.
  - In ERR, busy=0.
- in_ready=1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM. Exactly one byte is consumed per handshake cycle; in_valid low stalls the FSM with no state change.
- Boundaries:
  - LEN=DEPTH-BASE_ADDR is accepted.
  - The last word lands at address BASE_ADDR+LEN-1; mem_addr never wraps.
  - clr in a receiving or RUN state is ignored.
  - rst_n low at any point, including mid-DATA, aborts immediately to reset values. Partially loaded memory contents are not rolled back.

Optional Feature:
LOADER_TIMEOUT_EN
- Defined:
  - An idle counter runs in LEN_HI, LEN_LO, DATA and CSUM, and clears on each accepted byte.
  - On reaching TIMEOUT_CYC -> ERR with code 3.
- Undefined:
  - No counter; the loader waits indefinitely.
  - err_code 3 is never produced.

Test Plan:
- Good load: stream 0xA5, 0x00, 0x0B, the 11 words 280a00c8 28020001 0e94a000 21430000 0e94a000 14431000 2c630001 0e94a000 3460fffc 2542fffe fc000000, then the correct XOR. Required: 11 mem_we pulses at addresses 0..10 with matching data; cpu_hold falls the cycle after CSUM; when the core model raises cpu_halted, done=1 and cpu_hold=1.
- Bad checksum: same frame with CSUM XOR 0x01 -> err=1, err_code=2, cpu_hold stays 1, in_ready=0. Then clr -> IDLE with err=0.
- Length overflow: with DEPTH=1024, LEN=0x0401 -> err_code=1 after LEN_LO and zero mem_we pulses. LEN=0x0400 is accepted.
- Garbage and stalls: bytes 0x00, 0xFF, 0x5A before 0xA5 are ignored. in_valid toggling every other cycle during DATA still yields the correct words at the correct addresses.
- Reset mid-frame: rst_n low after 6 payload bytes. Outputs return to reset values asynchronously; a following full good frame loads correctly from BASE_ADDR.
- Timeout (LOADER_TIMEOUT_EN defined, TIMEOUT_CYC=16): stop after 2 payload bytes -> err_code=3 exactly 16 cycles after the last accepted byte.
